icache: RTL and testbench

Direct-mapped, one-word-block instruction cache between the pipelined datapath's fetch stage and the memory controller. It answers fetch requests combinationally on a hit. On a miss it runs a single-word fill over the controller's iREN/iwait handshake, writes the returned word into the frame, and then serves the fetch as a hit. It also keeps hit and miss counters for performance runs.

---
 rtl/icache.sv | 134 +++++++++++++
 tb/tb_icache.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/icache.sv
// icache: direct-mapped, one-word-block instruction cache.
// A hit is answered combinationally. A miss runs a single-word fill over the
// iREN/iwait handshake, and the fetch is then served as a hit from the new frame.
// Hit and miss counters are kept for performance runs.
module icache #(
    parameter int SETS = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);
    localparam int IDX = $clog2(SETS);
    localparam int TAG = 30 - IDX;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    state_t state_reg, state_next;

    logic           valid_reg [SETS];
    logic [TAG-1:0] tag_reg   [SETS];
    logic [31:0]    data_reg  [SETS];

    logic [31:0] hit_count_reg;
    logic [31:0] miss_count_reg;

    logic [IDX-1:0] index;
    logic [TAG-1:0] tag;
    logic           match;
    logic           fill_en;
    logic           miss_start;
    logic [SETS-1:0] frame_we;

    // Word-aligned fetches: the byte offset carries no information here.
    logic unused_addr_bits;
    assign unused_addr_bits = ^imemaddr[1:0];

    assign index = imemaddr[IDX+1:2];
    assign tag   = imemaddr[31:IDX+2];
    assign match = valid_reg[index] && (tag_reg[index] == tag);

    // No hit-under-miss: a matching frame is ignored while a fill is pending.
    assign ihit       = imemREN && match && (state_reg == IDLE);
    assign imemload   = data_reg[index];
    assign iREN       = (state_reg == FETCH);
    assign iaddr      = imemaddr;
    assign hit_count  = hit_count_reg;
    assign miss_count = miss_count_reg;

    // One write enable per frame, selected by the fetch index during a fill.
    for (genvar gi = 0; gi < SETS; gi++) begin : g_frame_we
        assign frame_we[gi] = fill_en && (index == IDX'(gi));
    end

    // Next-state logic: start a fill on a miss, finish it when the controller answers.
    always_comb begin
        state_next = state_reg;
        fill_en    = 1'b0;
        miss_start = 1'b0;
        case (state_reg)
            IDLE: begin
                if (imemREN && !match) begin
                    state_next = FETCH;
                    miss_start = 1'b1;
                end
            end
            FETCH: begin
                if (!imemREN) begin
                    // Fetch withdrawn: abandon the fill and leave every frame intact.
                    state_next = IDLE;
                end else if (!iwait) begin
                    fill_en    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Frame storage: cleared on reset, overwritten unconditionally on a fill.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < SETS; i++) begin
                valid_reg[i] <= 1'b0;
                tag_reg[i]   <= '0;
                data_reg[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < SETS; i++) begin
                if (frame_we[i]) begin
                    valid_reg[i] <= 1'b1;
                    tag_reg[i]   <= tag;
                    data_reg[i]  <= iload;
                end
            end
        end
    end

    // Performance counters; both wrap naturally at 32 bits.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hit_count_reg  <= '0;
            miss_count_reg <= '0;
        end else begin
            if (ihit) begin
                hit_count_reg <= hit_count_reg + 32'd1;
            end
            if (miss_start) begin
                miss_count_reg <= miss_count_reg + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_icache.sv
// tb_icache: directed vector table, hand sequences for the multi-cycle corners,
// and random fetches checked against a transaction-level cache model.
module tb_icache;
    localparam int SETS = 16;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    icache #(.SETS(SETS)) dut (
        .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
        .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
        .iwait(iwait), .iload(iload), .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int passes = 0;

    // Model: which word address each frame holds, plus expected counters.
    bit          mdl_valid [SETS];
    logic [29:0] mdl_word  [SETS];
    int unsigned exp_hits = 0;
    int unsigned exp_miss = 0;

    typedef struct {
        logic [31:0] addr;
        int          stall;
        bit          hit;
        logic [31:0] data;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    // Backing memory contents as a pure function of the word address.
    function automatic logic [31:0] memword(input logic [31:0] a);
        logic [29:0] w;
        w = a[31:2];
        if (w == 30'd0)  return 32'h3C010001;
        if (w == 30'd16) return 32'hAAAA5555;
        return {2'b00, w} * 32'h9E3779B1 + 32'h01234567;
    endfunction

    function automatic bit mdl_hit(input logic [31:0] a);
        int idx;
        idx = int'((a >> 2) % SETS);
        return mdl_valid[idx] && (mdl_word[idx] == a[31:2]);
    endfunction

    task automatic mdl_reset();
        for (int i = 0; i < SETS; i++) begin
            mdl_valid[i] = 1'b0;
            mdl_word[i]  = '0;
        end
        exp_hits = 0;
        exp_miss = 0;
    endtask

    // One fetch served to completion; the controller answers after 'stall' busy cycles.
    // Entered and left one time unit after a rising edge.
    task automatic fetch(input logic [31:0] addr, input int stall,
                         input bit exp_hit, input logic [31:0] exp_data);
        int  lat;
        int  st;
        bit  got;
        bit  was_hit;
        int  exp_lat;
        int  idx;
        lat = 0; st = 0; got = 1'b0;
        was_hit = mdl_hit(addr);
        exp_lat = exp_hit ? 0 : stall + 2;
        imemREN = 1'b1; imemaddr = addr; iwait = 1'b1; iload = $urandom;
        for (int c = 0; c < 64 && !got; c++) begin
            #1;
            chk("iaddr", iaddr, addr);
            chk("iren", {31'd0, iREN}, {31'd0, (!exp_hit && c >= 1 && c <= stall + 1)});
            if (ihit) begin
                got = 1'b1;
                lat = c;
                chk("imemload", imemload, exp_data);
            end else if (iREN) begin
                if (st == stall) begin
                    iwait = 1'b0;
                    iload = memword(addr);
                end else begin
                    iwait = 1'b1;
                    iload = $urandom;
                    st++;
                end
            end
            @(posedge CLK); #1;
            iwait = 1'b1;
            iload = $urandom;
        end
        if (!got) chk("fetch_timeout", 32'd0, 32'd1);
        chk("latency", lat, exp_lat);
        idx = int'((addr >> 2) % SETS);
        if (!was_hit) begin
            mdl_valid[idx] = 1'b1;
            mdl_word[idx]  = addr[31:2];
            exp_miss++;
        end
        exp_hits++;
        chk("hit_count", hit_count, exp_hits);
        chk("miss_count", miss_count, exp_miss);
        imemREN = 1'b0;
        $display("fetch addr=%h stall=%0d hit=%0b lat=%0d data=%h", addr, stall, exp_hit, lat, imemload);
    endtask

    initial begin
        nRST = 1'b0; imemREN = 1'b0; imemaddr = 32'h00001234; iwait = 1'b1; iload = '0;
        mdl_reset();
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_ihit", {31'd0, ihit}, 32'd0);
        chk("rst_iren", {31'd0, iREN}, 32'd0);
        chk("rst_imemload", imemload, 32'd0);
        chk("rst_iaddr", iaddr, 32'h00001234);
        chk("rst_hits", hit_count, 32'd0);
        chk("rst_miss", miss_count, 32'd0);
        nRST = 1'b1;
        @(posedge CLK); #1;

        // Cold miss, three hits, conflict eviction and refill of frame 0, long stall.
        tbl[0] = '{32'h00000000, 2,  1'b0, 32'h3C010001};
        tbl[1] = '{32'h00000000, 0,  1'b1, 32'h3C010001};
        tbl[2] = '{32'h00000000, 0,  1'b1, 32'h3C010001};
        tbl[3] = '{32'h00000000, 0,  1'b1, 32'h3C010001};
        tbl[4] = '{32'h00000040, 1,  1'b0, 32'hAAAA5555};
        tbl[5] = '{32'h00000000, 0,  1'b0, 32'h3C010001};
        tbl[6] = '{32'h00000000, 0,  1'b1, 32'h3C010001};
        tbl[7] = '{32'h00000104, 10, 1'b0, memword(32'h00000104)};
        for (int i = 0; i < 8; i++) begin
            fetch(tbl[i].addr, tbl[i].stall, tbl[i].hit, tbl[i].data);
        end
        chk("table_miss_total", miss_count, 32'd4);
        chk("table_hit_total", hit_count, 32'd8);

        // Request withdrawn while the controller is still busy.
        imemREN = 1'b1; imemaddr = 32'h00000008; iwait = 1'b1;
        #1;
        chk("wd_t_iren", {31'd0, iREN}, 32'd0);
        @(posedge CLK); #1;
        chk("wd_fetch_iren", {31'd0, iREN}, 32'd1);
        imemREN = 1'b0;
        #1;
        chk("wd_drop_iren", {31'd0, iREN}, 32'd1);
        chk("wd_drop_ihit", {31'd0, ihit}, 32'd0);
        @(posedge CLK); #1;
        chk("wd_idle_iren", {31'd0, iREN}, 32'd0);
        exp_miss++;
        chk("wd_miss", miss_count, exp_miss);
        $display("withdraw addr=00000008 miss_count=%0d", miss_count);
        fetch(32'h00000008, 0, 1'b0, memword(32'h00000008));

        // Reset asserted with a fill pending.
        imemREN = 1'b1; imemaddr = 32'h0000000C; iwait = 1'b1;
        @(posedge CLK); #1;
        chk("rf_iren", {31'd0, iREN}, 32'd1);
        nRST = 1'b0;
        #1;
        chk("rf_rst_iren", {31'd0, iREN}, 32'd0);
        chk("rf_rst_ihit", {31'd0, ihit}, 32'd0);
        chk("rf_rst_imemload", imemload, 32'd0);
        chk("rf_rst_hits", hit_count, 32'd0);
        chk("rf_rst_miss", miss_count, 32'd0);
        $display("reset_mid_fetch iren=%0b hits=%0d misses=%0d", iREN, hit_count, miss_count);
        mdl_reset();
        imemREN = 1'b0;
        @(posedge CLK); #1;
        nRST = 1'b1;
        @(posedge CLK); #1;
        fetch(32'h00000000, 0, 1'b0, 32'h3C010001);

        // Random fetches over a small address pool to mix hits, misses and conflicts.
        for (int n = 0; n < 200; n++) begin
            logic [31:0] a;
            a = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2)
                | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) begin
                imemREN = 1'b0; imemaddr = a;
                #1;
                chk("idle_ihit", {31'd0, ihit}, 32'd0);
                chk("idle_iren", {31'd0, iREN}, 32'd0);
                @(posedge CLK); #1;
            end
            fetch(a, $urandom_range(0, 4), mdl_hit(a), memword(a));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
